rx_leds: RTL and testbench
==========================

# rx_leds

UART-receive demo block: it deserialises 8N1 frames arriving on a single serial input line. It drives the low nibble of each correctly received byte onto four LEDs. It is a top-level example sitting directly between the board's RX pin and its LED bank. It contains its own baud tick generator, input synchroniser, receive FSM and LED register.

## Interface
- `BAUDRATE`, default `` `B115200 `` (104 at 12 MHz): clock cycles per serial bit; legal range 4..65535.
- `clk`  in  1  system clock (12 MHz on target board).
- `rstn`  in  1  reset; one clock, reset is synchronous and active-low.
- `rx`  in  1  asynchronous serial input, idle high.
- `leds`  out  4  bits [3:0] of last accepted byte; `leds[0]` = data bit 0.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1) before any use; the FSM sees only the synchronised signal `rxs`.
- Falling-edge detector on `rxs` (previous-value flop, reset value 1) produces `start_edge`.
- Baud counter: 16-bit, cleared when not in a receiving state.
  - In START, it emits a tick after `BAUDRATE/2` cycles (integer division).
  - In DATA and STOP, it emits a tick every `BAUDRATE` cycles.
- FSM states:
  - IDLE: on `start_edge` -> START.
  - START: on tick, if `rxs`==0 -> DATA with bit index 0; else -> IDLE (glitch rejected, nothing latched).
  - DATA: on each tick, shift `rxs` into the shift register LSB-first and increment the 3-bit index; after the 8th sample -> STOP.
  - STOP: on tick, sample `rxs` and go to LOAD.
  - LOAD: one cycle. Sets `leds <= shift[3:0]` if the byte is accepted (see Configuration), then -> IDLE.
- The full byte is held internally; only bits [3:0] are visible.
- `leds` holds its value between frames, through glitches and through rejected frames.
- Reset (any state, any time): FSM -> IDLE, counter and bit index cleared, shift register 0x00, `leds` = 4'b0000, synchroniser and edge flops = 1.
- A line held low when reset is released does not start a frame; a 1->0 transition is required.
- A new start edge during the stop bit's second half (FSM already in IDLE) is received normally. Back-to-back frames with one stop bit are therefore supported.

## Timing
- Reset values: `leds` = 0, state IDLE.
- Sample points relative to the clock on which `start_edge` is asserted:
  - start bit: +`BAUDRATE/2`
  - data bit k: +`BAUDRATE/2` + (k+1)·`BAUDRATE`
  - stop bit: +`BAUDRATE/2` + 9·`BAUDRATE`
- `start_edge` is asserted 3 clocks after the `rx` pin falls (2 sync + 1 edge).
- `leds` updates 1 clock after the stop-bit sample (LOAD), so the pin-to-LED latency is 3 + `BAUDRATE/2` + 9·`BAUDRATE` + 2 clocks. The bench tolerance is ±2 clocks.
- Timing tolerance: receives correctly with up to ±4 % baud mismatch.

## Configuration
- `RX_LEDS_FRAMING_CHECK_EN` defined: if the stop-bit sample is 0, the byte is discarded, `leds` is unchanged, and the FSM returns to IDLE. It then waits for `rxs` to go high before a new start edge can be detected, which the edge detector guarantees.
- Not defined: the stop bit is sampled but ignored; the byte is always latched in LOAD.

## Test plan
- Reset: hold `rstn`=0 for 5 clocks with `rx`=1 -> `leds`=4'b0000; release -> `leds` stays 0 with idle line.
- Send 0x55 at `BAUDRATE`=104, then 0x4B ('K') after 4 bit-times idle -> `leds`=4'b0101 after the first frame, 4'b1011 after the second, each at the latency given in Timing.
- Glitch: `rx` low for `BAUDRATE/4` cycles then high -> no update, FSM back in IDLE; a following 0xA3 -> `leds`=4'b0011.
- Framing error: send 0x0F with stop bit 0 -> with macro defined `leds` is unchanged; without the macro `leds`=4'b1111.
- Back-to-back: 0x01, 0x02, 0x0C with no idle gap -> `leds` steps 0001, 0010, 1100.
- Reset mid-frame: assert `rstn`=0 during data bit 4 of 0xFF -> `leds`=0 next clock; a following 0x06 -> `leds`=4'b0110.

Source files
------------

// File: rtl/rx_leds.sv
// rtl/rx_leds.sv - 8N1 UART receiver showing the low nibble of each accepted byte on four LEDs
// Optional stop-bit framing check: define RX_LEDS_FRAMING_CHECK_EN.
`ifndef B115200
`define B115200 104
`endif

module rx_leds #(
  parameter int BAUDRATE = `B115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [3:0] leds
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} state_t;

  localparam logic [15:0] HALF_M1 = 16'(BAUDRATE / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(BAUDRATE - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  leds_q, leds_d;
  logic        rx_s1_q, rxs_q, prev_q;
  logic        v1_q, v2_q, armed_q;
  logic        start_edge, tick;
`ifdef RX_LEDS_FRAMING_CHECK_EN
  logic        stop_q, stop_d;
`endif

  // v1/v2 mark when rxs carries real pin data; armed needs a genuine high first,
  // so a line held low across reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1_q <= 1'b1;
      rxs_q   <= 1'b1;
      prev_q  <= 1'b1;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      rx_s1_q <= rx;
      rxs_q   <= rx_s1_q;
      prev_q  <= rxs_q;
      v1_q    <= 1'b1;
      v2_q    <= v1_q;
      armed_q <= armed_q | (v2_q & rxs_q);
    end
  end

  assign start_edge = armed_q & prev_q & ~rxs_q;
  assign tick       = (state_q == START) ? (cnt_q == HALF_M1) : (cnt_q == FULL_M1);

  always_comb begin
    state_d = state_q;
    cnt_d   = 16'd0;
    idx_d   = idx_q;
    shift_d = shift_q;
    leds_d  = leds_q;
`ifdef RX_LEDS_FRAMING_CHECK_EN
    stop_d  = stop_q;
`endif
    case (state_q)
      IDLE: if (start_edge) state_d = START;
      START: begin
        if (tick) begin
          if (!rxs_q) begin
            state_d = DATA;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {rxs_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (tick) begin
`ifdef RX_LEDS_FRAMING_CHECK_EN
          stop_d  = rxs_q;
`endif
          state_d = LOAD;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      LOAD: begin
`ifdef RX_LEDS_FRAMING_CHECK_EN
        if (stop_q) leds_d = shift_q[3:0];
`else
        leds_d = shift_q[3:0];
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      leds_q  <= 4'b0000;
`ifdef RX_LEDS_FRAMING_CHECK_EN
      stop_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      leds_q  <= leds_d;
`ifdef RX_LEDS_FRAMING_CHECK_EN
      stop_q  <= stop_d;
`endif
    end
  end

  assign leds = leds_q;

endmodule

// File: tb/tb_rx_leds.sv
// tb/tb_rx_leds.sv - directed self-checking bench for rx_leds
`timescale 1ns/1ps

module tb_rx_leds;
  localparam int B = 104;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx;
  logic [3:0] leds;

  int pass_cnt = 0;
  int total_cnt = 0;

  rx_leds #(.BAUDRATE(B)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .leds (leds)
  );

  always #5 clk = ~clk;

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_leds(input string name, input logic [3:0] exp);
    total_cnt++;
    if (leds !== exp) $display("FAIL %s: leds got %b expected %b", name, leds, exp);
    else pass_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clks(B);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(B);
    end
    rx = stop;
    wait_clks(B);
    rx = 1'b1;
  endtask

  // Frame starts now; returns clocks until leds moves away from its current value.
  task automatic send_timed(input logic [7:0] b, output int lat);
    logic [3:0] old;
    old = leds;
    lat = 0;
    fork
      send_byte(b, 1'b1);
      begin
        while (leds === old && lat < 1200) begin
          wait_clks(1);
          lat++;
        end
      end
    join
  endtask

  task automatic check_latency(input string name, input int lat);
    total_cnt++;
    if (lat < 991 || lat > 995) $display("FAIL %s: latency got %0d expected 991..995", name, lat);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    rx   = 1'b1;
    wait_clks(5);
    check_leds("reset_hold", 4'b0000);
    rstn = 1'b1;
    wait_clks(50);
    check_leds("reset_release_idle", 4'b0000);
    rstn = 1'b0;
    rx   = 1'b0;
    wait_clks(5);
    rstn = 1'b1;
    wait_clks(200);
    rx = 1'b1;
    wait_clks(1200);
    check_leds("reset_release_line_low", 4'b0000);
  endtask

  task automatic test_basic();
    int lat;
    send_timed(8'h55, lat);
    check_leds("frame_0x55", 4'b0101);
    check_latency("latency_0x55", lat);
    wait_clks(4 * B);
    send_timed(8'h4B, lat);
    check_leds("frame_0x4B", 4'b1011);
    check_latency("latency_0x4B", lat);
    wait_clks(4 * B);
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    wait_clks(B / 4);
    rx = 1'b1;
    wait_clks(2 * B);
    check_leds("glitch_rejected", 4'b1011);
    send_byte(8'hA3, 1'b1);
    wait_clks(2 * B);
    check_leds("after_glitch_0xA3", 4'b0011);
  endtask

  task automatic test_framing();
    send_byte(8'h0F, 1'b0);
    wait_clks(2 * B);
`ifdef RX_LEDS_FRAMING_CHECK_EN
    check_leds("framing_error_discard", 4'b0011);
`else
    check_leds("framing_error_ignored", 4'b1111);
`endif
    wait_clks(2 * B);
  endtask

  task automatic test_back_to_back();
    send_byte(8'h01, 1'b1);
    check_leds("b2b_0x01", 4'b0001);
    send_byte(8'h02, 1'b1);
    check_leds("b2b_0x02", 4'b0010);
    send_byte(8'h0C, 1'b1);
    check_leds("b2b_0x0C", 4'b1100);
    wait_clks(2 * B);
  endtask

  task automatic test_reset_mid_frame();
    fork
      send_byte(8'hFF, 1'b1);
      begin
        wait_clks(570);
        rstn = 1'b0;
        wait_clks(1);
        check_leds("mid_frame_reset", 4'b0000);
        rstn = 1'b1;
      end
    join
    wait_clks(2 * B);
    send_byte(8'h06, 1'b1);
    wait_clks(2 * B);
    check_leds("after_reset_0x06", 4'b0110);
  endtask

  initial begin
    rstn = 1'b0;
    rx   = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
